// File: rtl/dff_pre_clr_if.sv
// Data-side bundle for the dff_pre_clr storage cell: D in, Q/Qn out.
// Optional macro DFF_CE_EN adds the active-high clock enable CE.
interface dff_pre_clr_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
`ifdef DFF_CE_EN
    logic             ce;
`endif

    modport master (
        output d,
`ifdef DFF_CE_EN
        output ce,
`endif
        input  q,
        input  qn
    );

    modport slave (
        input  d,
`ifdef DFF_CE_EN
        input  ce,
`endif
        output q,
        output qn
    );
endinterface

// File: rtl/dff_pre_clr.sv
// 74x74-style D flip-flop with async active-low clear (wins) and preset, WIDTH bits.
// Optional macro DFF_CE_EN adds a synchronous clock enable on the data path.
module dff_pre_clr #(
    parameter int WIDTH = 1
) (
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_pre_n,
    dff_pre_clr_if.slave      bus
);
    logic [WIDTH-1:0] r_s;
    logic             w_pre_act_n;
    logic             w_both_act;

    // NOTE: preset is qualified by CLR so that releasing CLR while PRE is still low
    // produces a falling edge here and the state flips to all-ones, as a real 74x74 does.
    assign w_pre_act_n = i_pre_n | ~i_clr_n;
    assign w_both_act  = ~i_clr_n & ~i_pre_n;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_clr_n or negedge w_pre_act_n) begin
        if (!i_clr_n) begin
            r_s <= '0;
        end else if (!w_pre_act_n) begin
            r_s <= '1;
`ifdef DFF_CE_EN
        end else if (bus.ce) begin
            r_s <= bus.d;
        end
`else
        end else begin
            r_s <= bus.d;
        end
`endif
    end

    // Both controls low forces the "both high" output state regardless of S.
    assign bus.q  = w_both_act ? '1 : r_s;
    assign bus.qn = w_both_act ? '1 : ~r_s;
endmodule

// File: tb/tb_dff_pre_clr.sv
// Directed self-checking bench for dff_pre_clr with a spec-level state model.
// Builds with or without DFF_CE_EN.
module tb_dff_pre_clr;
    localparam int WIDTH = 4;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             clk   = 1'b0;
    logic             clr_n = 1'b1;
    logic             pre_n = 1'b1;
    logic [WIDTH-1:0] m_s   = '0;
    bit               model_valid = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;

    dff_pre_clr_if #(.WIDTH(WIDTH)) bus ();

    dff_pre_clr #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_clr_n (clr_n),
        .i_pre_n (pre_n),
        .bus     (bus.slave)
    );

    function automatic logic ce_now();
`ifdef DFF_CE_EN
        return bus.ce;
`else
        return 1'b1;
`endif
    endfunction

    // Spec output rule: both controls asserted -> both outputs high, else Q=S, Qn=~S.
    function automatic logic [WIDTH-1:0] exp_q();
        return (!clr_n && !pre_n) ? ONES : m_s;
    endfunction

    function automatic logic [WIDTH-1:0] exp_qn();
        return (!clr_n && !pre_n) ? ONES : ~m_s;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] want_q,
                         input logic [WIDTH-1:0] want_qn);
        n_vec++;
        if (bus.q !== want_q || bus.qn !== want_qn) begin
            n_err++;
            $display("FAIL %s: got Q=%h Qn=%h, expected Q=%h Qn=%h",
                     name, bus.q, bus.qn, want_q, want_qn);
        end
    endtask

    // Level-sensitive async controls applied to the model, CLR has priority.
    task automatic set_ctrl(input logic c, input logic p);
        clr_n = c;
        pre_n = p;
        if (!c)      m_s = '0;
        else if (!p) m_s = ONES;
        #1;
    endtask

    task automatic tick();
        #4;
        if (clr_n && pre_n && ce_now()) m_s = bus.d;
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (model_valid) check("model", exp_q(), exp_qn());
    end

    initial begin
        bus.d = '0;
`ifdef DFF_CE_EN
        bus.ce = 1'b1;
`endif
        #1;
        // 1: both asserted, then PRE released alone
        set_ctrl(1'b0, 1'b0);
        model_valid = 1'b1;
        check("both_low", ONES, ONES);
        set_ctrl(1'b0, 1'b1);
        check("pre_release", 4'h0, ONES);
        // releasing only CLR leaves all-ones
        set_ctrl(1'b0, 1'b0);
        set_ctrl(1'b1, 1'b0);
        check("clr_release_only", ONES, 4'h0);
        set_ctrl(1'b1, 1'b1);
        check("after_clr_release", ONES, 4'h0);

        // 2: preset alone, then release with D changed and no edge
        set_ctrl(1'b1, 1'b1);
        tick();
        set_ctrl(1'b1, 1'b0);
        check("preset", ONES, 4'h0);
        bus.d = ONES;
        set_ctrl(1'b1, 1'b1);
        check("preset_hold", ONES, 4'h0);

        // 3: clocked capture and D changes between edges
        bus.d = 4'h0;
        tick();
        check("cap_0", 4'h0, ONES);
        bus.d = 4'h5;
        tick();
        check("cap_5", 4'h5, 4'hA);
        bus.d = 4'h3;
        #2 bus.d = 4'hC;
        #1 check("d_toggle_hold", 4'h5, 4'hA);

        // 4: CLR pulse mid-cycle and edge while CLR asserted
        bus.d = ONES;
        tick();
        check("cap_F", ONES, 4'h0);
        set_ctrl(1'b0, 1'b1);
        check("clr_pulse", 4'h0, ONES);
        tick();
        check("edge_during_clr", 4'h0, ONES);
        set_ctrl(1'b1, 1'b1);
        check("clr_released", 4'h0, ONES);
        bus.d = 4'h9;
        tick();
        check("cap_9", 4'h9, 4'h6);

        // Edge coincident with CLR assertion: clear wins
        bus.d = ONES;
        #4;
        clk   = 1'b1;
        clr_n = 1'b0;
        m_s   = '0;
        #5 clk = 1'b0;
        #1 check("edge_coincident_clr", 4'h0, ONES);
        set_ctrl(1'b1, 1'b1);

        // 5: both asserted then released together
        set_ctrl(1'b0, 1'b0);
        check("both_low_again", ONES, ONES);
        set_ctrl(1'b1, 1'b1);
        check("both_released", 4'h0, ONES);
        bus.d = 4'h6;
        tick();
        check("cap_6", 4'h6, 4'h9);

`ifdef DFF_CE_EN
        // 6: clock enable gating
        bus.d  = 4'hA;
        bus.ce = 1'b1;
        tick();
        check("ce_cap_A", 4'hA, 4'h5);
        bus.d  = 4'h3;
        bus.ce = 1'b0;
        tick();
        check("ce_hold", 4'hA, 4'h5);
        set_ctrl(1'b0, 1'b1);
        check("ce_off_clr", 4'h0, ONES);
        set_ctrl(1'b1, 1'b0);
        check("ce_off_pre", ONES, 4'h0);
        set_ctrl(1'b1, 1'b1);
        bus.ce = 1'b1;
`else
        bus.d = 4'hA;
        tick();
        check("cap_A", 4'hA, 4'h5);
        bus.d = 4'h3;
        tick();
        check("cap_3", 4'h3, 4'hC);
`endif
        // short directed sweep, checked by the model on each edge
        for (int i = 0; i < 8; i++) begin
            bus.d = WIDTH'((i * 7 + 2) % 16);
            tick();
        end
        bus.d = 4'hB;
        tick();
        check("final_cap", 4'hB, 4'h4);

        model_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dff_pre_clr.md
Name: dff_pre_clr

Overview:
Edge-triggered D flip-flop with asynchronous active-low preset (PRE) and active-low clear (CLR), patterned on one section of a 74x74. It provides true (Q) and complementary (Qn) outputs. It serves as a generic storage and synchronisation cell in control logic. The data path is vectorised by WIDTH, and all bits share the same clock and asynchronous controls.

Parameters:
WIDTH, 1, number of stored bits; D, Q and Qn are WIDTH wide.

Ports:
CLK  input  1  clock; rising-edge triggered.
CLR  input  1  asynchronous active-low reset (clear); forces stored state to 0.
PRE  input  1  asynchronous active-low preset; forces stored state to all-ones.
D  input  WIDTH  data, sampled on the CLK rising edge.
Q  output  WIDTH  true output.
Qn  output  WIDTH  complementary output.
(With the optional feature only: CE  input  1  clock enable.)

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on CLR.
- Internal state register S (WIDTH bits). Priority order: CLR, then PRE, then clock.
- CLR=0 (any PRE): S=0 immediately, with no clock required; held while CLR=0.
- CLR=1, PRE=0: S=all-ones immediately; held while PRE=0.
- CLR=1, PRE=1: on each CLK rising edge, S <= D. Between edges, S holds; D changes have no effect.
- Output mapping:
  - CLR=1 or PRE=1: Q=S and Qn=~S.
  - CLR=0 and PRE=0 (both asserted): Q=all-ones and Qn=all-ones, the 74x74 "both high" state, combinational from the controls.
- Release of the asynchronous controls:
  - From the both-asserted state, S is 0 because CLR has priority, so after PRE and CLR both return to 1 the outputs are Q=0, Qn=all-ones.
  - Releasing only PRE leaves S=0; releasing only CLR leaves S=all-ones.
- Clock edge coincident with any asserted asynchronous control: the asynchronous control wins and D is ignored.
- Clock edge coincident with control deassertion: D is not captured on that edge. The first capture is the next rising edge with PRE=CLR=1 already stable.
- Power-up with no control asserted: S is X until a clock edge or an asynchronous control. The bench must assert CLR or PRE first.
- Latency: Q updates on the same CLK rising edge that samples D, with no pipeline stage. Asynchronous controls act with zero cycles of latency.
- No unknown-to-known conversion: X on D propagates to Q and Qn on capture.

Optional Feature:
Macro DFF_CE_EN.
- Defined: adds input port CE (1 bit, active-high). With PRE=CLR=1, S <= D on a CLK rising edge only when CE=1; CE=0 holds S. Asynchronous PRE and CLR behave identically regardless of CE.
- Undefined: no CE port exists, and every CLK rising edge with PRE=CLR=1 loads D.

Test Plan:
1. PRE=0, CLR=0, CLK=0, D=0 at time 0 -> Q=1, Qn=1. Then PRE=1 with CLR=0 -> Q=0, Qn=1 with no clock edge.
2. PRE=0, CLR=1, CLK held at 0, D=0 -> Q=1, Qn=0 immediately. Then PRE=1, CLR=1, D=1 with no CLK edge -> Q stays 1, Qn stays 0.
3. PRE=1, CLR=1, D=0, CLK rising edge -> Q=0, Qn=1. D=1, CLK rising edge -> Q=1, Qn=0. D toggling between edges -> Q unchanged.
4. Q=1 from clocking, then CLR pulsed low mid-cycle with no edge -> Q=0, Qn=1 during and after the pulse. CLK rising edge while CLR=0 with D=1 -> Q stays 0.
5. PRE=0 and CLR=0 together, then both released to 1 in the same step -> Q=1, Qn=1 while asserted; Q=0, Qn=1 after release.
6. DFF_CE_EN defined, WIDTH=4, PRE=CLR=1: D=4'hA, CE=1, edge -> Q=4'hA, Qn=4'h5. D=4'h3, CE=0, edge -> Q stays 4'hA. CLR=0 with CE=0 -> Q=4'h0.
